div_unit: RTL

- Iterative radix-2 divider used by the EX stage for MIPS DIV/DIVU.
- It sits directly upstream of the pipeline stall controller. Its `stall_request` output drives the controller's EX-stage stall request.
- While `stall_request` is high, the controller freezes PC, IF, ID and EX. The divider releases the request in the cycle its result is valid, and the EX stage latches that result into HI/LO.

---
 rtl/div_unit_pkg.sv | 17 +
 rtl/div_unit_if.sv | 41 ++++
 rtl/div_sign_adjust.sv | 31 +++
 rtl/div_unit.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/div_unit_pkg.sv
// Shared definitions for the iterative radix-2 divider: state encoding,
// default operand width and the fixed divide-by-zero quotient.
package div_unit_pkg;

    localparam int DIV_DATA_WIDTH = 32;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_CALC = 2'b01,
        S_DONE = 2'b10
    } div_state_e;

    // Architecturally undefined result, pinned to all-ones so that
    // software sees a deterministic value.
    localparam logic [DIV_DATA_WIDTH-1:0] DIV_ZERO_QUOTIENT = '1;

endpackage

// File: rtl/div_unit_if.sv
// Request/response bundle between the EX stage and the divider.
// master = EX stage side, slave = divider side.
interface div_unit_if #(
    parameter int DATA_WIDTH = 32
);

    logic                  en;
    logic                  is_signed;
    logic [DATA_WIDTH-1:0] dividend;
    logic [DATA_WIDTH-1:0] divisor;
    logic                  flush;
    logic                  stall_request;
    logic                  done;
    logic [DATA_WIDTH-1:0] quotient;
    logic [DATA_WIDTH-1:0] remainder;

    modport master (
        output en,
        output is_signed,
        output dividend,
        output divisor,
        output flush,
        input  stall_request,
        input  done,
        input  quotient,
        input  remainder
    );

    modport slave (
        input  en,
        input  is_signed,
        input  dividend,
        input  divisor,
        input  flush,
        output stall_request,
        output done,
        output quotient,
        output remainder
    );

endinterface

// File: rtl/div_sign_adjust.sv
// Two-lane conditional two's-complement negation. Used once to take the
// magnitudes of the operands and once to restore the signs of the results.
module div_sign_adjust #(
    parameter int DATA_WIDTH = 32
) (
    input  logic [DATA_WIDTH-1:0] a_in,
    input  logic                  a_neg,
    input  logic [DATA_WIDTH-1:0] b_in,
    input  logic                  b_neg,
    output logic [DATA_WIDTH-1:0] a_out,
    output logic [DATA_WIDTH-1:0] b_out
);

    // Negation wraps: the most negative value maps onto itself, which is
    // exactly what the overflow case (MIN / -1) needs.
    function automatic logic signed [DATA_WIDTH-1:0] cond_neg(
        input logic signed [DATA_WIDTH-1:0] v,
        input logic                         neg
    );
        return neg ? -v : v;
    endfunction

    logic signed [DATA_WIDTH-1:0] a_s;
    logic signed [DATA_WIDTH-1:0] b_s;

    assign a_s   = cond_neg(signed'(a_in), a_neg);
    assign b_s   = cond_neg(signed'(b_in), b_neg);
    assign a_out = unsigned'(a_s);
    assign b_out = unsigned'(b_s);

endmodule

// File: rtl/div_unit.sv
// Iterative restoring radix-2 divider for MIPS DIV/DIVU. One quotient bit
// per cycle; holds the pipeline through stall_request until the result is
// ready, then pulses done for a single cycle while HI/LO are latched.
module div_unit
    import div_unit_pkg::*;
#(
    parameter int DATA_WIDTH = DIV_DATA_WIDTH,
    parameter int CNT_WIDTH  = 6
) (
    input  logic      clk,
    input  logic      rst,
    div_unit_if.slave bus
);

    div_state_e state;
    div_state_e state_next;

    logic [CNT_WIDTH-1:0]  counter;
    logic [DATA_WIDTH-1:0] rem_acc;
    logic [DATA_WIDTH-1:0] quot_acc;
    logic [DATA_WIDTH-1:0] div_abs;
    logic                  sign_a;
    logic                  sign_b;

    logic [DATA_WIDTH-1:0] dvd_abs;
    logic [DATA_WIDTH-1:0] dvs_abs;
    logic                  start;
    logic                  div_zero;
    logic                  last_step;

    logic [DATA_WIDTH:0]   rem_shift;
    logic                  trial_ok;
    logic [DATA_WIDTH-1:0] rem_step;
    logic [DATA_WIDTH-1:0] quot_step;
    logic [DATA_WIDTH-1:0] q_fixed;
    logic [DATA_WIDTH-1:0] r_fixed;

    logic                  stall_req;
    logic                  done_pulse;
    logic [DATA_WIDTH-1:0] quotient_r;
    logic [DATA_WIDTH-1:0] remainder_r;

    assign start     = (state == S_IDLE) && bus.en && !bus.flush;
    assign div_zero  = (bus.divisor == '0);
    assign last_step = (counter == CNT_WIDTH'(DATA_WIDTH - 1));

    // Operand magnitudes; only DIV treats the MSB as a sign.
    div_sign_adjust #(.DATA_WIDTH(DATA_WIDTH)) u_operand_abs (
        .a_in  (bus.dividend),
        .a_neg (bus.is_signed & bus.dividend[DATA_WIDTH-1]),
        .b_in  (bus.divisor),
        .b_neg (bus.is_signed & bus.divisor[DATA_WIDTH-1]),
        .a_out (dvd_abs),
        .b_out (dvs_abs)
    );

    // One restoring step: shift {rem, quot} left, try to subtract divisor.
    // The partial remainder is always below the divisor, so the shifted
    // value fits in DATA_WIDTH+1 bits and a successful difference fits in
    // DATA_WIDTH bits.
    assign rem_shift = {rem_acc, quot_acc[DATA_WIDTH-1]};
    assign trial_ok  = (rem_shift >= {1'b0, div_abs});
    assign rem_step  = trial_ok ? (rem_shift[DATA_WIDTH-1:0] - div_abs)
                                : rem_shift[DATA_WIDTH-1:0];
    assign quot_step = {quot_acc[DATA_WIDTH-2:0], trial_ok};

    // Result sign restore; latched signs are already gated by is_signed.
    div_sign_adjust #(.DATA_WIDTH(DATA_WIDTH)) u_result_sign (
        .a_in  (quot_step),
        .a_neg (sign_a ^ sign_b),
        .b_in  (rem_step),
        .b_neg (sign_a),
        .a_out (q_fixed),
        .b_out (r_fixed)
    );

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; flush overrides everything, including a start.
    always_comb begin
        state_next = state;
        if (bus.flush) begin
            state_next = S_IDLE;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.en) begin
                        state_next = div_zero ? S_DONE : S_CALC;
                    end
                end
                S_CALC: begin
                    if (last_step) begin
                        state_next = S_DONE;
                    end
                end
                S_DONE:  state_next = S_IDLE;
                default: state_next = S_IDLE;
            endcase
        end
    end

    // Outputs to the stall controller and EX stage; stall drops in DONE so
    // the pipeline advances on the edge that ends it.
    always_comb begin
        stall_req  = 1'b0;
        done_pulse = 1'b0;
        case (state)
            S_IDLE:  stall_req  = bus.en && !bus.flush;
            S_CALC:  stall_req  = 1'b1;
            S_DONE:  done_pulse = 1'b1;
            default: begin
                stall_req  = 1'b0;
                done_pulse = 1'b0;
            end
        endcase
    end

    // Iteration counter and architecturally visible results.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            counter     <= '0;
            quotient_r  <= '0;
            remainder_r <= '0;
        end else if (bus.flush) begin
            counter <= '0;
        end else if (start) begin
            counter <= '0;
            if (div_zero) begin
                quotient_r  <= DATA_WIDTH'(DIV_ZERO_QUOTIENT);
                remainder_r <= bus.dividend;
            end
        end else if (state == S_CALC) begin
            counter <= counter + CNT_WIDTH'(1);
            if (last_step) begin
                quotient_r  <= q_fixed;
                remainder_r <= r_fixed;
            end
        end
    end

    // Working datapath: operands captured on start, then shifted each step.
    always_ff @(posedge clk) begin
        if (start) begin
            rem_acc  <= '0;
            quot_acc <= dvd_abs;
            div_abs  <= dvs_abs;
            sign_a   <= bus.is_signed & bus.dividend[DATA_WIDTH-1];
            sign_b   <= bus.is_signed & bus.divisor[DATA_WIDTH-1];
        end else if (state == S_CALC) begin
            rem_acc  <= rem_step;
            quot_acc <= quot_step;
        end
    end

    assign bus.stall_request = stall_req;
    assign bus.done          = done_pulse;
    assign bus.quotient      = quotient_r;
    assign bus.remainder     = remainder_r;

endmodule
